// File: rtl/systolic_matmul_engine.sv
// Purpose: output-stationary ROWS x COLS signed GEMM engine computing C = A x B over run-time length K.
// Latency: first c_valid_o K+ROWS+COLS cycles after start with gap-free operands; 1 cycle for K=0.
// Backpressure: operands accepted only in FEED (a_ready_o); result rows hold until c_ready_i.
//
// Ports:
//   clock_i, reset_i           : clock, synchronous active-high reset
//   start_i, k_len_i           : job start (taken in IDLE only) and reduction length (clamped to K_MAX)
//   a_valid_i/a_ready_o        : operand beat handshake; a_rows_i = column k of A, b_columns_i = row k of B
//   c_valid_o/c_ready_i        : result row handshake; c_row_o = C[c_row_idx_o][*]
//   busy_o, done_o             : engine not idle; one-cycle pulse after the last row is accepted
//   sat_flag_o                 : sticky saturation flag, present only when SYSTOLIC_ACC_SAT_EN is defined
// Optional build macro: SYSTOLIC_ACC_SAT_EN (saturating accumulators instead of wrapping).
module systolic_matmul_engine #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int K_MAX  = 256,
    parameter int K_W    = $clog2(K_MAX + 1),
    parameter int RI_W   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    start_i,
    input  logic [K_W-1:0]          k_len_i,
    input  logic                    a_valid_i,
    output logic                    a_ready_o,
    input  logic [ROWS*DATA_W-1:0]  a_rows_i,
    input  logic [COLS*DATA_W-1:0]  b_columns_i,
    output logic                    c_valid_o,
    input  logic                    c_ready_i,
    output logic [COLS*ACC_W-1:0]   c_row_o,
    output logic [RI_W-1:0]         c_row_idx_o,
`ifdef SYSTOLIC_ACC_SAT_EN
    output logic                    sat_flag_o,
`endif
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int FL_W = $clog2(ROWS + COLS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_FLUSH,
        ST_OUTPUT
    } state_t;

    state_t            state;
    logic [K_W-1:0]    k_len;
    logic [K_W-1:0]    beat_cnt;
    logic [FL_W-1:0]   flush_cnt;
    logic [RI_W-1:0]   row_idx;
    logic              done;
    logic [K_W-1:0]    k_cap;
    logic              start_take;
    logic              hs;

    // Operand/tag pipelines: {tag, data} per PE; accumulators per PE.
    logic [ROWS-1:0][DATA_W:0]            a_inj, a_skew;
    logic [COLS-1:0][DATA_W:0]            b_inj, b_skew;
    logic [ROWS-1:0][COLS-1:0][DATA_W:0]  a_reg, a_nx, b_reg, b_nx;
    logic [ROWS-1:0][COLS-1:0][ACC_W-1:0] acc, acc_nx;
    logic [ROWS-1:0][COLS-1:0]            sat_hit;

    assign k_cap      = (k_len_i > K_W'(K_MAX)) ? K_W'(K_MAX) : k_len_i;
    // A start in the done cycle is ignored so the earliest restart is the cycle after.
    assign start_take = (state == ST_IDLE) && start_i && !done;
    assign hs         = (state == ST_FEED) && a_valid_i;

    // Non-handshake cycles inject zero data with a cleared tag.
    always_comb begin
        a_inj = '0;
        b_inj = '0;
        for (int i = 0; i < ROWS; i++) begin
            a_inj[i] = hs ? {1'b1, a_rows_i[i*DATA_W +: DATA_W]} : '0;
        end
        for (int j = 0; j < COLS; j++) begin
            b_inj[j] = hs ? {1'b1, b_columns_i[j*DATA_W +: DATA_W]} : '0;
        end
    end

    genvar gi, gj;

    // Input skew: lane i of A waits i cycles, lane j of B waits j cycles.
    for (gi = 0; gi < ROWS; gi++) begin : g_askew
        if (gi == 0) begin : g_direct
            assign a_skew[gi] = a_inj[gi];
        end else begin : g_delay
            logic [DATA_W:0] dl [gi];
            always_ff @(posedge clock_i) begin
                if (reset_i) begin
                    for (int s = 0; s < gi; s++) dl[s] <= '0;
                end else begin
                    dl[0] <= a_inj[gi];
                    for (int s = 1; s < gi; s++) dl[s] <= dl[s-1];
                end
            end
            assign a_skew[gi] = dl[gi-1];
        end
    end

    for (gj = 0; gj < COLS; gj++) begin : g_bskew
        if (gj == 0) begin : g_direct
            assign b_skew[gj] = b_inj[gj];
        end else begin : g_delay
            logic [DATA_W:0] dl [gj];
            always_ff @(posedge clock_i) begin
                if (reset_i) begin
                    for (int s = 0; s < gj; s++) dl[s] <= '0;
                end else begin
                    dl[0] <= b_inj[gj];
                    for (int s = 1; s < gj; s++) dl[s] <= dl[s-1];
                end
            end
            assign b_skew[gj] = dl[gj-1];
        end
    end

    // PE grid: a flows right, b flows down; each PE accumulates when both tags are set.
    for (gi = 0; gi < ROWS; gi++) begin : g_row
        for (gj = 0; gj < COLS; gj++) begin : g_col
            logic                       fire;
            logic signed [2*DATA_W-1:0] prod;

            if (gj == 0) begin : g_ain
                assign a_nx[gi][gj] = a_skew[gi];
            end else begin : g_ain
                assign a_nx[gi][gj] = a_reg[gi][gj-1];
            end
            if (gi == 0) begin : g_bin
                assign b_nx[gi][gj] = b_skew[gj];
            end else begin : g_bin
                assign b_nx[gi][gj] = b_reg[gi-1][gj];
            end

            assign fire = a_reg[gi][gj][DATA_W] & b_reg[gi][gj][DATA_W];
            assign prod = $signed(a_reg[gi][gj][DATA_W-1:0]) * $signed(b_reg[gi][gj][DATA_W-1:0]);

`ifdef SYSTOLIC_ACC_SAT_EN
            // One guard bit exposes overflow; clamp to the signed ACC_W range.
            logic [ACC_W:0] sum;
            logic           ovf;
            assign sum = {acc[gi][gj][ACC_W-1], acc[gi][gj]}
                       + {{(ACC_W+1-2*DATA_W){prod[2*DATA_W-1]}}, prod};
            assign ovf = sum[ACC_W] ^ sum[ACC_W-1];
            assign sat_hit[gi][gj] = fire & ovf;
            assign acc_nx[gi][gj] = !fire ? acc[gi][gj] :
                                    !ovf  ? sum[ACC_W-1:0] :
                                    sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                               : {1'b0, {(ACC_W-1){1'b1}}};
`else
            logic [ACC_W-1:0] sum;
            assign sum = acc[gi][gj] + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
            assign sat_hit[gi][gj] = 1'b0;
            assign acc_nx[gi][gj] = fire ? sum : acc[gi][gj];
`endif
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
        end else begin
            a_reg <= a_nx;
            b_reg <= b_nx;
            acc   <= start_take ? '0 : acc_nx;
        end
    end

`ifdef SYSTOLIC_ACC_SAT_EN
    logic sat_flag;
    always_ff @(posedge clock_i) begin
        if (reset_i || start_take) sat_flag <= 1'b0;
        else if (|sat_hit)         sat_flag <= 1'b1;
    end
    assign sat_flag_o = sat_flag;
`else
    logic unused_sat;
    assign unused_sat = |sat_hit;
`endif

    // Control FSM
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state     <= ST_IDLE;
            k_len     <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            row_idx   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_take) begin
                        k_len    <= k_cap;
                        beat_cnt <= '0;
                        row_idx  <= '0;
                        state    <= (k_cap != '0) ? ST_FEED : ST_OUTPUT;
                    end
                end
                ST_FEED: begin
                    if (a_valid_i) begin
                        beat_cnt <= beat_cnt + K_W'(1);
                        if (beat_cnt == k_len - K_W'(1)) begin
                            flush_cnt <= '0;
                            state     <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    // Long enough for the last beat to reach PE(ROWS-1, COLS-1).
                    if (flush_cnt == FL_W'(ROWS + COLS - 2)) state <= ST_OUTPUT;
                    else flush_cnt <= flush_cnt + FL_W'(1);
                end
                ST_OUTPUT: begin
                    if (c_ready_i) begin
                        if (row_idx == RI_W'(ROWS - 1)) begin
                            row_idx <= '0;
                            done    <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            row_idx <= row_idx + RI_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs are forced low while reset is asserted.
    assign a_ready_o   = (state == ST_FEED) && !reset_i;
    assign c_valid_o   = (state == ST_OUTPUT) && !reset_i;
    assign busy_o      = (state != ST_IDLE) && !reset_i;
    assign done_o      = done && !reset_i;
    assign c_row_idx_o = reset_i ? '0 : row_idx;

    always_comb begin
        c_row_o = '0;
        for (int j = 0; j < COLS; j++) begin
            c_row_o[j*ACC_W +: ACC_W] = c_valid_o ? acc[row_idx][j] : '0;
        end
    end

endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Purpose: randomized self-checking bench for systolic_matmul_engine against a matrix-product model.
// Latency: n/a (bench).
// Backpressure: drives gap patterns on operands and stall patterns on results.
module tb_systolic_matmul_engine;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int K_MAX  = 256;
    localparam int K_W    = $clog2(K_MAX + 1);
    localparam int RI_W   = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   start = 1'b0;
    logic [K_W-1:0]         k_len = '0;
    logic                   a_valid = 1'b0;
    logic                   a_ready;
    logic [ROWS*DATA_W-1:0] a_rows = '0;
    logic [COLS*DATA_W-1:0] b_cols = '0;
    logic                   c_valid;
    logic                   c_ready = 1'b1;
    logic [COLS*ACC_W-1:0]  c_row;
    logic [RI_W-1:0]        c_idx;
    logic                   busy;
    logic                   done;
`ifdef SYSTOLIC_ACC_SAT_EN
    logic                   sat_flag;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    int     a_m [K_MAX][ROWS];
    int     b_m [K_MAX][COLS];
    longint c_m [ROWS][COLS];
    bit     sat_m;

    systolic_matmul_engine #(.DATA_W(DATA_W), .ACC_W(ACC_W), .ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX)) dut (
        .clock_i    (clk),
        .reset_i    (rst),
        .start_i    (start),
        .k_len_i    (k_len),
        .a_valid_i  (a_valid),
        .a_ready_o  (a_ready),
        .a_rows_i   (a_rows),
        .b_columns_i(b_cols),
        .c_valid_o  (c_valid),
        .c_ready_i  (c_ready),
        .c_row_o    (c_row),
        .c_row_idx_o(c_idx),
`ifdef SYSTOLIC_ACC_SAT_EN
        .sat_flag_o (sat_flag),
`endif
        .busy_o     (busy),
        .done_o     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // C[i][j] = sum_k A[i][k]*B[k][j], reduced in k order at ACC_W bits.
    task automatic compute_model(input int kk);
        longint lim_hi = (longint'(1) <<< (ACC_W - 1)) - 1;
        longint lim_lo = -(longint'(1) <<< (ACC_W - 1));
        logic [ACC_W-1:0] t;
        sat_m = 1'b0;
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                longint s = 0;
                for (int k = 0; k < kk; k++) begin
                    s = s + longint'(a_m[k][i]) * longint'(b_m[k][j]);
`ifdef SYSTOLIC_ACC_SAT_EN
                    if (s > lim_hi) begin s = lim_hi; sat_m = 1'b1; end
                    if (s < lim_lo) begin s = lim_lo; sat_m = 1'b1; end
`else
                    t = s[ACC_W-1:0];
                    s = longint'($signed(t));
`endif
                end
                c_m[i][j] = s;
            end
        end
    endtask

    task automatic fill_random(input int kk);
        byte v;
        for (int k = 0; k < kk; k++) begin
            for (int i = 0; i < ROWS; i++) begin v = byte'($urandom_range(0, 255)); a_m[k][i] = int'(v); end
            for (int j = 0; j < COLS; j++) begin v = byte'($urandom_range(0, 255)); b_m[k][j] = int'(v); end
        end
    endtask

    task automatic fill_const(input int kk, input int av, input int bv);
        for (int k = 0; k < kk; k++) begin
            for (int i = 0; i < ROWS; i++) a_m[k][i] = av;
            for (int j = 0; j < COLS; j++) b_m[k][j] = bv;
        end
    endtask

    task automatic drive_beat(input int k);
        for (int i = 0; i < ROWS; i++) a_rows[i*DATA_W +: DATA_W] = DATA_W'(a_m[k][i]);
        for (int j = 0; j < COLS; j++) b_cols[j*DATA_W +: DATA_W] = DATA_W'(b_m[k][j]);
    endtask

    // bub: 0 none, 1 alternate starting with a beat, 2 random. bp: 0 none, 1 stall row 1 x3, 2 random.
    task automatic run_job(input int k_req, input int bub, input int bp);
        int kk = (k_req > K_MAX) ? K_MAX : k_req;
        int beat = 0, rows = 0, first = -1, last_hs = 0;
        int ready_cyc = 0, bubbles = 0, stall = 0, done_cnt = 0;
        bit tog = 1'b0, give;
        logic signed [ACC_W-1:0] v;
        compute_model(kk);
        @(negedge clk);
        start = 1'b1;
        k_len = K_W'(k_req);
        @(negedge clk);
        start = 1'b0;
        for (int t = 1; t <= kk * 4 + 100; t++) begin
            a_valid = 1'b0;
            if (a_ready) begin
                ready_cyc++;
                give = (bub == 0) || (bub == 1 && !tog) || (bub == 2 && $urandom_range(0, 2) != 0);
                tog = !tog;
                if (give) begin
                    drive_beat(beat);
                    a_valid = 1'b1;
                    beat++;
                    last_hs = t;
                end else begin
                    bubbles++;
                end
            end
            c_ready = 1'b1;
            if (c_valid) begin
                if (first < 0) begin
                    first = t;
                    check("latency", t, (kk == 0) ? 1 : last_hs + ROWS + COLS);
                end
                if (bp == 1 && c_idx == 1 && stall < 3) begin c_ready = 1'b0; stall++; end
                if (bp == 2) c_ready = ($urandom_range(0, 1) == 1);
                check("row_idx", c_idx, rows);
                for (int j = 0; j < COLS; j++) begin
                    v = c_row[j*ACC_W +: ACC_W];
                    check($sformatf("c[%0d][%0d]", rows, j), v, c_m[rows % ROWS][j]);
                end
                if (c_ready) rows++;
            end
            if (done) begin
                done_cnt++;
                check("done_cvalid", c_valid, 0);
                check("done_busy", busy, 0);
                check("done_rows", rows, ROWS);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check("start_in_done_ignored", busy, 0);
                check("done_one_cycle", done, 0);
                break;
            end
            @(negedge clk);
        end
        c_ready = 1'b1;
        check("rows_delivered", rows, ROWS);
        check("done_count", done_cnt, 1);
        check("feed_cycles", ready_cyc, kk + bubbles);
        if (bp == 1) check("stall_cycles", stall, 3);
`ifdef SYSTOLIC_ACC_SAT_EN
        check("sat_flag", sat_flag, sat_m);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a_ready"}, a_ready, 0);
        check({tag, "_c_valid"}, c_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_c_idx"}, c_idx, 0);
        check({tag, "_c_row"}, (c_row != '0) ? 1 : 0, 0);
`ifdef SYSTOLIC_ACC_SAT_EN
        check({tag, "_sat"}, sat_flag, 0);
`endif
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("in_reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("after_reset");

        // K=1, a=[1,2,3,4], b=1 -> row i holds i+1
        for (int i = 0; i < ROWS; i++) a_m[0][i] = i + 1;
        for (int j = 0; j < COLS; j++) b_m[0][j] = 1;
        run_job(1, 0, 0);

        // Identity A, B = 1..16, gap-free then alternating gaps
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < ROWS; i++) a_m[k][i] = (i == k) ? 1 : 0;
            for (int j = 0; j < COLS; j++) b_m[k][j] = 4 * k + j + 1;
        end
        run_job(4, 0, 0);
        run_job(4, 1, 0);

        // Signed extremes
        fill_const(2, -128, -128);
        run_job(2, 0, 0);
        fill_const(2, -1, 127);
        run_job(2, 0, 0);

        // Backpressure on row 1
        fill_random(5);
        run_job(5, 0, 1);

        // Zero-length job after a nonzero one: accumulators must be cleared
        run_job(0, 0, 0);

        // Overflow at ACC_W=16: wrap to 0 or saturate to 32767
        fill_const(4, -128, -128);
        run_job(4, 0, 0);

        // Reset in the middle of FEED
        fill_random(10);
        @(negedge clk);
        start = 1'b1;
        k_len = K_W'(10);
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 3; t++) begin
            drive_beat(t);
            a_valid = 1'b1;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("mid_feed_reset");
        rst = 1'b0;
        a_valid = 1'b0;
        @(negedge clk);
        check_all_zero("post_mid_reset");
        fill_random(7);
        run_job(7, 0, 0);

        // Random jobs with random gaps and stalls
        for (int n = 0; n < 8; n++) begin
            int kr = $urandom_range(1, 24);
            fill_random(kr);
            run_job(kr, 2, 2);
        end

        // Length above K_MAX is clamped
        fill_random(K_MAX);
        run_job(300, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
